// File: rtl/img_pkg.sv
// Shared constants for the 3x3 window stream: border modes, default geometry, tap order.
package img_pkg;

  localparam int BORDER_VALID = 0;
  localparam int BORDER_ZERO  = 1;

  localparam int DEF_PIX_W = 8;
  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;

  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;
  localparam int P4 = 4;
  localparam int P5 = 5;
  localparam int P6 = 6;
  localparam int P7 = 7;
  localparam int P8 = 8;

  // Tap position by [row][column], row 0 = top, column 0 = left.
  localparam int TAP [3][3] = '{'{P0, P1, P2}, '{P3, P4, P5}, '{P6, P7, P8}};

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/line_buf.sv
// Single-port line RAM, read-before-write: the read port returns the old word in the write cycle.
module line_buf #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic [WIDTH-1:0]         rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_dat = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_dat;
  end

endmodule

// File: rtl/win3x3_stream.sv
// Raster-stream 3x3 window generator; window registered one cycle after its completing step.
// Input stalls while the output register is full; WIN3X3_COORD_EN exports the centre coordinate.
module win3x3_stream
  import img_pkg::*;
#(
  parameter int PIX_W       = DEF_PIX_W,
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int BORDER_MODE = BORDER_VALID
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [PIX_W-1:0]   in_pix_i,
  output logic               win_valid_o,
  input  logic               win_ready_i,
  output logic [9*PIX_W-1:0] win_o,
  output logic               frame_done_o
`ifdef WIN3X3_COORD_EN
  ,
  output logic [$clog2(IMG_W)-1:0] win_x_o,
  output logic [$clog2(IMG_H)-1:0] win_y_o
`endif
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_PEN  = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_PEN  = YW'(IMG_H - 2);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam bit IS_ZERO = (BORDER_MODE == BORDER_ZERO);

  state_t state, state_nxt;
  logic live;
  logic [XW-1:0] cx, ox;
  logic [YW-1:0] cy, oy;
  logic [PIX_W-1:0] a_r [3];
  logic [PIX_W-1:0] b_r [3];
  logic [PIX_W-1:0] col [3];
  logic [PIX_W-1:0] pix_new, lb0_rd, lb1_rd;
  logic step, step_ok, has_cen, in_end, cen_end, interior, emit, last_cen, win_last;
  logic [9*PIX_W-1:0] win_nxt;

  assign step_ok    = !win_valid_o || win_ready_i;
  assign in_ready_o = live && (state == ST_RUN) && step_ok;

  // A centre exists once IMG_W+1 steps of the frame have been taken.
  assign has_cen  = (state == ST_FLUSH) || (cy > Y_ONE) || (cy == Y_ONE && cx != '0);
  assign in_end   = (state == ST_RUN) && cx == X_LAST && cy == Y_LAST;
  assign cen_end  = (state == ST_FLUSH) && ox == X_LAST && oy == Y_LAST;
  assign interior = ox != '0 && ox != X_LAST && oy != '0 && oy != Y_LAST;
  assign emit     = step && has_cen && (IS_ZERO || interior);
  assign last_cen = IS_ZERO ? (ox == X_LAST && oy == Y_LAST) : (ox == X_PEN && oy == Y_PEN);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    pix_new   = '0;
    case (state)
      ST_RUN: begin
        step    = in_valid_i && in_ready_o;
        pix_new = in_pix_i;
        if (step && in_end && IS_ZERO) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        step = step_ok;
        if (step && cen_end) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // lb0 holds the line two above the input, lb1 the line directly above.
  line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk(clk_i), .we(step), .addr(cx), .wr_dat(lb1_rd), .rd_dat(lb0_rd)
  );
  line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk(clk_i), .we(step), .addr(cx), .wr_dat(pix_new), .rd_dat(lb1_rd)
  );

  assign col[0] = lb0_rd;
  assign col[1] = lb1_rd;
  assign col[2] = pix_new;

  // Border taps are forced to zero so line-end wrap never leaks neighbouring lines.
  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < 3; r++) begin
      if (!((r == 0 && oy == '0) || (r == 2 && oy == Y_LAST))) begin
        if (ox != '0)     win_nxt[TAP[r][0]*PIX_W +: PIX_W] = a_r[r];
        win_nxt[TAP[r][1]*PIX_W +: PIX_W] = b_r[r];
        if (ox != X_LAST) win_nxt[TAP[r][2]*PIX_W +: PIX_W] = col[r];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      live         <= 1'b0;
      cx           <= '0;
      cy           <= '0;
      ox           <= '0;
      oy           <= '0;
      win_valid_o  <= 1'b0;
      win_o        <= '0;
      win_last     <= 1'b0;
      frame_done_o <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        a_r[r] <= '0;
        b_r[r] <= '0;
      end
    end else begin
      live         <= 1'b1;
      frame_done_o <= win_valid_o && win_ready_i && win_last;
      if (step) begin
        for (int r = 0; r < 3; r++) begin
          a_r[r] <= b_r[r];
          b_r[r] <= col[r];
        end
        if (in_end || cen_end) begin
          cx <= '0;
          cy <= '0;
        end else if (cx == X_LAST) begin
          cx <= '0;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
        // ZERO mode keeps the centre running through the flush steps.
        if ((in_end && !IS_ZERO) || cen_end) begin
          ox <= '0;
          oy <= '0;
        end else if (has_cen) begin
          if (ox == X_LAST) begin
            ox <= '0;
            oy <= oy + 1'b1;
          end else begin
            ox <= ox + 1'b1;
          end
        end
      end
      if (step_ok) begin
        win_valid_o <= emit;
        if (emit) begin
          win_o    <= win_nxt;
          win_last <= last_cen;
        end
      end
    end
  end

`ifdef WIN3X3_COORD_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      win_x_o <= '0;
      win_y_o <= '0;
    end else if (step_ok && emit) begin
      win_x_o <= ox;
      win_y_o <= oy;
    end
  end
`else
  // Centre coordinates stay internal.
`endif

endmodule
